// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first, WIDTH steps per operation.
// Optional SERIAL_ADD_SUB_EN adds a sub port that turns the operation into a-b.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             ack,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   psum;
  logic [CNT_W-1:0]   cnt;
  logic               c;

  logic               sum_bit;
  logic               c_next;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

  assign sum_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_next  = (a_sh[0] & b_sh[0]) | (b_sh[0] & c) | (c & a_sh[0]);

  // Subtraction is a + ~b + 1; the forced carry-in replaces ci.
  always_comb begin
    b_load = b;
    c_load = ci;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            c     <= c_load;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_next;
          psum <= {sum_bit, psum[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // On the MSB step, c is the carry into the MSB and c_next the carry out.
          if (cnt == LAST) begin
            s     <= {sum_bit, psum[WIDTH-1:1]};
            co    <= c_next;
            ov    <= c ^ c_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl at WIDTH=8: vector table, random ops against an arithmetic model,
// and hand sequences for reset abort and simultaneous ack/start.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clrn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         ack;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ov;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] prev_s;
  logic         prev_co;
  logic         prev_ov;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [6];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .ack   (ack),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                       input logic vsub, output logic [W-1:0] es, output logic eco,
                       output logic eov);
    int unsigned ub;
    int          sa;
    int          sb;
    int          cin;
    int unsigned usum;
    int          ssum;
    ub   = vsub ? ((~int'(vb)) & 255) : int'(vb);
    cin  = vsub ? 1 : int'(vci);
    usum = int'(va) + ub + cin;
    es   = usum[W-1:0];
    eco  = usum[W];
    sa   = int'($signed(va));
    sb   = (ub > 127) ? int'(ub) - 256 : int'(ub);
    ssum = sa + sb + cin;
    eov  = (ssum > 127) || (ssum < -128);
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                        input logic vsub, input bit extra_start, input bit hold_check,
                        input bit ack_with_start);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    int           n;
    model(va, vb, vci, vsub, es, eco, eov);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_start", ready, 1);
    @(negedge clk);
    a = va; b = vb; ci = vci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = vsub;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'($urandom);
`endif
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 4) begin
        chk("run_hold_s", {s, co, ov}, {prev_s, prev_co, prev_ov});
        chk("busy_in_run", busy, 1);
        if (extra_start) start = 1'b1;
      end
      if (n == 5) start = 1'b0;
      if (done === 1'b1) break;
    end
    // done rises on the WIDTH-th RUN edge, so a synchronous consumer sees it at edge WIDTH+1.
    chk("latency", n, W);
    chk("sum", s, es);
    chk("co", co, eco);
    chk("ov", ov, eov);
    prev_s = es; prev_co = eco; prev_ov = eov;
    if (hold_check) begin
      repeat (6) @(posedge clk);
      #1;
      chk("done_hold", done, 1);
      chk("result_hold", {s, co, ov}, {es, eco, eov});
    end
    @(negedge clk);
    ack = 1'b1;
    if (ack_with_start) start = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    chk("ready_after_ack", ready, 1);
    chk("done_after_ack", done, 0);
    if (ack_with_start) begin
      @(posedge clk); #1;
      chk("no_start_on_ack", {ready, busy}, 2'b10);
    end
    $display("op a=%02h b=%02h ci=%0d sub=%0d -> s=%02h co=%0d ov=%0d (exp %02h %0d %0d)",
             va, vb, vci, vsub, s, co, ov, es, eco, eov);
  endtask

  initial begin
    int seen;
    vecs[0] = '{a: 8'h0F, b: 8'h01, ci: 1'b0, s: 8'h10, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b1, s: 8'h01, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, ci: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};

    clrn = 1'b0; start = 1'b0; ack = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
    #12;
    chk("reset_flags", {ready, busy, done}, 3'b100);
    chk("reset_result", {s, co, ov}, '0);
    @(negedge clk);
    clrn = 1'b1;

    // Table vectors; the 7F+01 entry also carries a stray start pulse during RUN.
    for (int i = 0; i < 6; i++) begin
      model(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, prev_s, prev_co, prev_ov);
      chk("table_model", {prev_s, prev_co, prev_ov}, {vecs[i].s, vecs[i].co, vecs[i].ov});
      if (i == 0) begin
        prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
      end else begin
        model(vecs[i-1].a, vecs[i-1].b, vecs[i-1].ci, 1'b0, prev_s, prev_co, prev_ov);
      end
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, (i == 2), (i == 0), 1'b0);
      chk("table_sum", {s, co, ov}, {vecs[i].s, vecs[i].co, vecs[i].ov});
    end

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sub_05_07", {s, co, ov}, {8'hFE, 1'b0, 1'b0});
`endif

    // Reset asserted on RUN edge 4 aborts the operation.
    @(negedge clk);
    a = 8'h33; b = 8'h44; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("abort_flags", {ready, busy, done}, 3'b100);
    chk("abort_result", {s, co, ov}, '0);
    @(negedge clk);
    clrn = 1'b1;
    prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    run_op(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // ack and start together in DONE: back to IDLE, nothing launched.
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, 1'($urandom), 1'b0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 clrn  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  operation request; accepted only on a rising edge where ready=1.
REQ-005 a  input  WIDTH  addend A; sampled on acceptance.
REQ-006 b  input  WIDTH  addend B; sampled on acceptance.
REQ-007 ci  input  1  carry-in; sampled on acceptance.
REQ-008 sub  input  1  subtract select; sampled on acceptance; port present only with SERIAL_ADD_SUB_EN.
REQ-009 ack  input  1  result acknowledge; consumed in DONE only.
REQ-010 ready  output  1  high iff state=IDLE.
REQ-011 busy  output  1  high iff state=RUN.
REQ-012 done  output  1  high iff state=DONE.
REQ-013 s  output  WIDTH  registered sum.
REQ-014 co  output  1  registered carry-out of the MSB.
REQ-015 ov  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start=1: load operand shift registers with a and b, load the carry flop with ci, and clear the bit counter.
REQ-018 RUN SHALL apply one full-adder step per clock on the operand LSBs and the carry flop.
  - sum bit = a0^b0^c.
  - new c = a0&b0 | b0&c | c&a0.
  - Shift both operand registers right by 1.
  - Shift the sum bit into the MSB of the partial-sum register.
REQ-019 On the RUN step where counter=WIDTH-1, save the pre-step carry as the MSB carry-in for ov.
REQ-020 RUN->DONE after exactly WIDTH RUN edges. On that same edge load s, co and ov from the final values.
REQ-021 Latency: start accepted at edge 0; done=1 after edge WIDTH+1 is sampled. Throughput: one operation per WIDTH+2 cycles minimum.
REQ-022 DONE->IDLE on ack=1. Without ack, DONE holds indefinitely and s/co/ov stay stable.
REQ-023 Ignored inputs:
  - start in RUN or DONE, including start and ack high in the same DONE cycle; no new operation starts.
  - ack in IDLE or RUN.
REQ-024 Input changes on a, b, ci and sub after acceptance SHALL NOT affect the running operation.
REQ-025 s, co and ov SHALL change only on the RUN->DONE edge or on reset; they hold the previous result through IDLE and RUN.
REQ-026 The sum is computed modulo 2^WIDTH; carry beyond the MSB appears only on co.

Reset
REQ-027 clrn=0 SHALL force, immediately and asynchronously:
  - state=IDLE, so ready=1, busy=0, done=0;
  - s=0, co=0, ov=0;
  - counter, carry flop and all shift registers = 0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse follows release.
REQ-029 After clrn is released, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-030 Macro SERIAL_ADD_SUB_EN.
  - Defined: the sub port exists. With sub=1 on acceptance, load ~b into the B register and force the carry flop to 1, ignoring ci, so that s=a-b. co=1 means no borrow.
  - Undefined: the sub port is absent and the block always adds a+b+ci.

Verification (WIDTH=8)
REQ-031 a=8'h0F, b=8'h01, ci=0, start pulse -> done=1 after edge 9 is sampled; s=8'h10, co=0, ov=0; done holds until ack, then ready=1.
REQ-032 a=8'hFF, b=8'h01, ci=1 -> s=8'h01, co=1, ov=0.
REQ-033 a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ov=1; an extra start pulse during RUN is ignored.
REQ-034 With SERIAL_ADD_SUB_EN: sub=1, a=8'h05, b=8'h07 -> s=8'hFE, co=0, ov=0.
REQ-035 clrn pulsed low at RUN edge 4 -> ready=1 and s=0 immediately; no done after release; the next start completes correctly.
REQ-036 In DONE, drive ack=1 and start=1 in the same cycle -> IDLE with no new operation; the next start is accepted normally.
